fetch_queue: RTL and testbench

Instruction fetch stage that sits directly upstream of the single-cycle core. It issues in-order word fetches to a latency-tolerant instruction memory port and holds returned instructions in a small queue, tagged with their PC. It hands {pc, instr} to the core over a valid/ready handshake. A redirect from the core's jal/jalr/branch resolution flushes the queue and restarts fetch at the new target, discarding any responses still in flight.

---
 rtl/fetch_queue.sv | 161 ++++++++++++++++
 tb/tb_fetch_queue.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue
// -----------------------------------------------------------------------------
// Instruction fetch stage in front of the single-cycle core. It issues
// in-order word fetches to a latency-tolerant instruction memory. Returned
// instructions wait in a small circular queue, each tagged with its PC, and
// are handed to the core as {pc, instr} over a valid/ready handshake. A
// redirect flushes the queue and restarts fetch at the new target. Responses
// that are still in flight when the redirect happens are discarded on return.
//
// Parameters
//   DEPTH     queue entries (power of two, >= 2); also caps allocated entries
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk, rst_n                      rising-edge clock, async active-low reset
//   imem_req_valid/ready/addr       fetch request channel (word-aligned addr)
//   imem_resp_valid/data            in-order responses, no backpressure
//   out_valid/ready, out_pc/instr   head instruction handed to the core
//   redirect_valid, redirect_pc     single-cycle flush-and-refetch pulse
//
// Configuration macro
//   FETCH_QUEUE_BYPASS_EN  when defined, a response that fills the head entry
//                          is forwarded to the outputs in the same cycle
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = IW + 1;
  localparam int DW = IW + 5;

  logic [31:0]   fpc_q, fpc_d;
  logic [PW-1:0] allocPtr_q, allocPtr_d;
  logic [PW-1:0] fillPtr_q, fillPtr_d;
  logic [PW-1:0] headPtr_q, headPtr_d;
  logic [DW-1:0] dropCnt_q, dropCnt_d;

  logic [31:0]      entryPc_q    [DEPTH];
  logic [31:0]      entryInstr_q [DEPTH];
  logic [DEPTH-1:0] filled_q;

  logic [IW-1:0] allocIdx, fillIdx, headIdx;
  logic [PW-1:0] outstanding;
  logic          qFull;
  logic          reqFire, respFill, respDrop, deqFire;
  logic [1:0]    unusedRedirLsbs;

  assign allocIdx    = allocPtr_q[IW-1:0];
  assign fillIdx     = fillPtr_q[IW-1:0];
  assign headIdx     = headPtr_q[IW-1:0];
  assign outstanding = allocPtr_q - fillPtr_q;

  // Redirect targets are forced word-aligned; the low bits carry no meaning.
  assign unusedRedirLsbs = redirect_pc[1:0];

  // Same index with opposite wrap bits means every entry is allocated.
  assign qFull = (allocPtr_q[IW-1:0] == headPtr_q[IW-1:0]) &&
                 (allocPtr_q[IW] != headPtr_q[IW]);

  // Gating with rst_n keeps the request low for the whole reset interval.
  assign imem_req_valid = rst_n && !redirect_valid && !qFull;
  assign imem_req_addr  = fpc_q;
  assign reqFire        = imem_req_valid && imem_req_ready;

  // A redirect overrides fills and drops; its drop-count update already
  // accounts for a response that arrives in the same cycle.
  assign respFill = imem_resp_valid && (dropCnt_q == '0) && !redirect_valid;
  assign respDrop = imem_resp_valid && (dropCnt_q != '0) && !redirect_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypassHit;

  // The head is the entry being filled right now: forward the memory data.
  assign bypassHit = respFill && (fillPtr_q == headPtr_q);
  assign out_valid = filled_q[headIdx] || bypassHit;
  assign out_instr = bypassHit ? imem_resp_data : entryInstr_q[headIdx];
`else
  assign out_valid = filled_q[headIdx];
  assign out_instr = entryInstr_q[headIdx];
`endif
  assign out_pc    = entryPc_q[headIdx];

  assign deqFire = out_valid && out_ready && !redirect_valid;

  always_comb begin
    fpc_d      = fpc_q;
    allocPtr_d = allocPtr_q;
    fillPtr_d  = fillPtr_q;
    headPtr_d  = headPtr_q;
    dropCnt_d  = dropCnt_q;
    if (redirect_valid) begin
      fpc_d      = {redirect_pc[31:2], 2'b00};
      allocPtr_d = '0;
      fillPtr_d  = '0;
      headPtr_d  = '0;
      // Every response still owed becomes stale. A response arriving now
      // retires one of them (either a pending drop or the fill in progress).
      dropCnt_d  = dropCnt_q + DW'(outstanding) - DW'(imem_resp_valid);
    end else begin
      if (reqFire) begin
        allocPtr_d = allocPtr_q + 1'b1;
        fpc_d      = fpc_q + 32'd4;
      end
      if (respFill) fillPtr_d = fillPtr_q + 1'b1;
      if (respDrop) dropCnt_d = dropCnt_q - 1'b1;
      if (deqFire)  headPtr_d = headPtr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q      <= RESET_PC;
      allocPtr_q <= '0;
      fillPtr_q  <= '0;
      headPtr_q  <= '0;
      dropCnt_q  <= '0;
      filled_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entryPc_q[i]    <= '0;
        entryInstr_q[i] <= '0;
      end
    end else begin
      fpc_q      <= fpc_d;
      allocPtr_q <= allocPtr_d;
      fillPtr_q  <= fillPtr_d;
      headPtr_q  <= headPtr_d;
      dropCnt_q  <= dropCnt_d;
      if (redirect_valid) begin
        filled_q <= '0;
      end else begin
        // Allocation and fill never target the same slot: a slot is only
        // reallocated after the head has moved past it.
        if (reqFire) begin
          entryPc_q[allocIdx] <= fpc_q;
          filled_q[allocIdx]  <= 1'b0;
        end
        if (respFill) begin
          entryInstr_q[fillIdx] <= imem_resp_data;
          filled_q[fillIdx]     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
// -----------------------------------------------------------------------------
// Self-checking bench for fetch_queue. A memory model answers requests in
// order after a configurable latency. Every accepted request pushes the
// expected {pc, instr} into a scoreboard queue, which a redirect or reset
// empties. A separate monitor pops and compares on every output handshake.
// The expected request address comes from a simple next-PC model. The
// expected request-valid comes from the scoreboard occupancy.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
  } memRsp_t;

  memRsp_t     inflight[$];
  logic [63:0] expQ[$];

  int total = 0;
  int bad = 0;
  int cycleNum = 0;
  int deqCount = 0;
  int reqCount = 0;
  int readyPct = 100;
  int outReadyPct = 100;
  int redirPct = 0;
  int memLat = 1;
  int memJit = 0;
  bit forceRedir = 1'b0;
  logic [31:0] forcePc = '0;
  logic [31:0] fpcModel = RESET_PC;
  bit prevRedir = 1'b0;
  bit armCap = 1'b0;
  int capCnt = 0;
  logic [31:0] capPc[3];

  // Contents of instruction memory: a fixed scramble of the address.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Sets the traffic mix, then runs the given number of cycles and stops
  // just after the negedge bookkeeping of the last one.
  task automatic applyStimulus(input int rdy, input int outRdy, input int redir,
                               input int lat, input int cycles);
    readyPct    = rdy;
    outReadyPct = outRdy;
    redirPct    = redir;
    memLat      = lat;
    if (cycles > 0) begin
      repeat (cycles) @(negedge clk);
      #2;
    end
  endtask

  // Leaves the bench at posedge+2 of the first cycle with rst_n high.
  task automatic pulseReset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    deqCount = 0;
    reqCount = 0;
  endtask

  // Takes effect in the cycle after the one in which it is called.
  task automatic armRedirect(input logic [31:0] pc);
    forceRedir = 1'b1;
    forcePc    = pc;
    armCap     = 1'b1;
    capCnt     = 0;
    for (int i = 0; i < 3; i++) capPc[i] = '1;
  endtask

  // Driver and memory model: bookkeeping at negedge+1, driving at posedge+1.
  initial begin : driver
    memRsp_t r;
    imem_req_ready  = 1'b0;
    out_ready       = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        inflight.delete();
        expQ.delete();
        fpcModel = RESET_PC;
      end else begin
        if (imem_resp_valid && inflight.size() > 0) r = inflight.pop_front();
        if (redirect_valid) begin
          expQ.delete();
          fpcModel = {redirect_pc[31:2], 2'b00};
        end else if (imem_req_valid && imem_req_ready) begin
          checkOutput("req_addr", imem_req_addr, fpcModel);
          expQ.push_back({fpcModel, memWord(fpcModel)});
          r.due  = cycleNum + memLat + int'($urandom_range(memJit));
          r.data = memWord(imem_req_addr);
          inflight.push_back(r);
          fpcModel = fpcModel + 32'd4;
          reqCount++;
        end
      end
      @(posedge clk);
      #1;
      cycleNum++;
      imem_req_ready = ($urandom_range(99) < readyPct);
      out_ready      = ($urandom_range(99) < outReadyPct);
      if (forceRedir) begin
        redirect_valid = 1'b1;
        redirect_pc    = forcePc;
        forceRedir     = 1'b0;
      end else if (redirPct > 0 && $urandom_range(99) < redirPct) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom & 32'h0000_0FFF;
      end else begin
        redirect_valid = 1'b0;
      end
      if (rst_n && inflight.size() > 0 && inflight[0].due <= cycleNum) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = inflight[0].data;
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
      end
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    logic        expReqValid;
    if (!rst_n) begin
      prevRedir = 1'b0;
    end else begin
      expReqValid = !redirect_valid && (expQ.size() < DEPTH);
      checkOutput("req_valid", imem_req_valid, expReqValid);
      if (prevRedir) checkOutput("valid_after_redirect", out_valid, 1'b0);
      if (out_valid && out_ready && !redirect_valid) begin
        deqCount++;
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL deq_unexpected: got pc %h, expected no output", out_pc);
        end else begin
          e = expQ.pop_front();
          checkOutput("out_pc", out_pc, e[63:32]);
          checkOutput("out_instr", out_instr, e[31:0]);
        end
        if (armCap && capCnt < 3) begin
          capPc[capCnt] = out_pc;
          capCnt++;
        end
      end
      prevRedir = redirect_valid;
    end
  end

  initial begin : mainSeq
    int expStream;
    // Reset values while rst_n is held low from time zero.
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_req_valid", imem_req_valid, 1'b0);
    checkOutput("reset_out_pc", out_pc, 32'h0);
    checkOutput("reset_out_instr", out_instr, 32'h0);
    checkOutput("reset_req_addr", imem_req_addr, RESET_PC);

    // Streaming at full rate with a 1-cycle memory.
    applyStimulus(100, 100, 0, 1, 0);
    pulseReset();
    applyStimulus(100, 100, 0, 1, 20);
`ifdef FETCH_QUEUE_BYPASS_EN
    expStream = 19;
`else
    expStream = 18;
`endif
    checkOutput("stream_throughput", deqCount, expStream);

    // Core stalled: exactly DEPTH requests, then the queue drains in order.
    applyStimulus(100, 0, 0, 1, 0);
    pulseReset();
    applyStimulus(100, 0, 0, 1, 10);
    checkOutput("full_req_count", reqCount, DEPTH);
    checkOutput("full_req_valid", imem_req_valid, 1'b0);
    applyStimulus(100, 100, 0, 1, 20);
    checkOutput("full_drain_count", deqCount, 20 - 2 + DEPTH - 2);

    // Redirect while two slow responses are in flight.
    applyStimulus(100, 100, 0, 3, 0);
    pulseReset();
    @(negedge clk);
    @(negedge clk);
    #2;
    armRedirect(32'h0000_0103);
    applyStimulus(100, 100, 0, 3, 20);
    checkOutput("redir_inflight_first_pc", capPc[0], 32'h0000_0100);

    // Redirect colliding with a dequeue and a response in the same cycle.
    applyStimulus(100, 100, 0, 1, 0);
    pulseReset();
    applyStimulus(100, 100, 0, 1, 8);
    armRedirect(32'h0000_0100);
    applyStimulus(100, 100, 0, 1, 15);
    checkOutput("redir_collide_pc0", capPc[0], 32'h0000_0100);
    checkOutput("redir_collide_pc1", capPc[1], 32'h0000_0104);

    // Fetch PC wraps from the top of the address space to zero.
    armRedirect(32'hFFFF_FFFA);
    applyStimulus(100, 100, 0, 1, 15);
    checkOutput("wrap_pc0", capPc[0], 32'hFFFF_FFF8);
    checkOutput("wrap_pc1", capPc[1], 32'hFFFF_FFFC);
    checkOutput("wrap_pc2", capPc[2], 32'h0000_0000);
    armCap = 1'b0;

    // Reset pulse with filled entries.
    applyStimulus(100, 0, 0, 1, 0);
    pulseReset();
    applyStimulus(100, 0, 0, 1, 4);
    checkOutput("pre_reset_out_valid", out_valid, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_out_valid", out_valid, 1'b0);
    checkOutput("mid_reset_req_valid", imem_req_valid, 1'b0);
    checkOutput("mid_reset_out_pc", out_pc, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    checkOutput("post_reset_req_valid", imem_req_valid, 1'b1);
    checkOutput("post_reset_req_addr", imem_req_addr, RESET_PC);

    // Randomized traffic with jittery memory and random redirects.
    memJit = 3;
    applyStimulus(70, 60, 4, 1, 600);
    applyStimulus(100, 100, 0, 1, 40);
    memJit = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
